// File: rtl/fp_pkg.sv
// Shared equalizer front-end definitions: sample type, lane-order note and
// the tap-count helper used to size tap windows.
package fp_pkg;

    localparam int FP_SAMPLE_WIDTH = 8;

    typedef logic signed [FP_SAMPLE_WIDTH-1:0] sample_t;

    localparam string FP_TAP_LANE_ORDER = "lane 0 = oldest";

    function automatic int total_tap(input int pre, input int main, input int post);
        return pre + main + post;
    endfunction

endpackage

// File: rtl/fp_skid_buffer.sv
// Generic 1-entry valid/ready skid buffer; o_s_ready is registered so no
// combinational path exists from i_m_ready back to the upstream side.
module fp_skid_buffer #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [WIDTH-1:0] i_s_data,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [WIDTH-1:0] o_m_data
);

    logic             r_m_valid;
    logic [WIDTH-1:0] r_m_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_s_ready;
    logic             w_fire;
    logic             w_m_load;
    logic             w_skid_valid_next;

    assign w_fire   = i_s_valid && r_s_ready;
    assign w_m_load = !r_m_valid || i_m_ready;

    // A parked word always moves out first; new input only parks when the output stalls.
    always_comb begin
        w_skid_valid_next = r_skid_valid;
        if (w_m_load) begin
            w_skid_valid_next = 1'b0;
        end else if (w_fire) begin
            w_skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_valid    <= 1'b0;
            r_m_data     <= RESET_DATA;
            r_skid_valid <= 1'b0;
            r_skid_data  <= RESET_DATA;
            r_s_ready    <= 1'b0;
        end else begin
            r_skid_valid <= w_skid_valid_next;
            r_s_ready    <= !w_skid_valid_next;
            if (w_m_load) begin
                if (r_skid_valid) begin
                    r_m_valid <= 1'b1;
                    r_m_data  <= r_skid_data;
                end else begin
                    r_m_valid <= w_fire;
                    if (w_fire) begin
                        r_m_data <= i_s_data;
                    end
                end
            end else if (w_fire) begin
                r_skid_data <= i_s_data;
            end
        end
    end

    assign o_s_ready = r_s_ready;
    assign o_m_valid = r_m_valid;
    assign o_m_data  = r_m_data;

endmodule

// File: rtl/fp_tap_window.sv
// Sliding tap-window assembler feeding the equalizer. Define
// FP_TAP_WINDOW_SKID_EN to insert a registered-ready skid stage at the output.
module fp_tap_window
    import fp_pkg::*;
#(
    parameter int MAIN_TAP         = 2,
    parameter int PRE_TAP          = 1,
    parameter int POST_TAP         = 1,
    parameter int INPUT_DATA_WIDTH = 8
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic                                                  in_sof,
    input  logic [INPUT_DATA_WIDTH*MAIN_TAP-1:0]                  input_data,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [INPUT_DATA_WIDTH*(PRE_TAP+MAIN_TAP+POST_TAP)-1:0] input_data_all,
    output logic                                                  out_pad
);

    localparam int TOTAL_TAP = total_tap(PRE_TAP, MAIN_TAP, POST_TAP);
    localparam int KEEP      = TOTAL_TAP - MAIN_TAP;
    localparam int CNT_W     = $clog2(TOTAL_TAP + 1);
    localparam int WIN_W     = INPUT_DATA_WIDTH * TOTAL_TAP;

    if (MAIN_TAP < 1) begin : g_chk_main
        $error("fp_tap_window: MAIN_TAP must be >= 1");
    end
    if (PRE_TAP < 0 || POST_TAP < 0) begin : g_chk_taps
        $error("fp_tap_window: PRE_TAP and POST_TAP must be >= 0");
    end
    if (INPUT_DATA_WIDTH < 7) begin : g_chk_width
        $error("fp_tap_window: INPUT_DATA_WIDTH must be >= 7");
    end

    logic [WIN_W-1:0] r_hist;
    logic [WIN_W-1:0] w_win;
    logic [CNT_W-1:0] r_fill;
    logic [CNT_W-1:0] w_fill_next;
    logic             w_pad_next;
    logic             w_xfer;

    assign w_xfer = in_valid && in_ready;

    // Older lanes shift down by MAIN_TAP (zeroed on sof); the new word lands on top.
    for (genvar gi = 0; gi < TOTAL_TAP; gi++) begin : g_lane
        if (gi < KEEP) begin : g_old
            assign w_win[gi*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH] =
                in_sof ? '0 : r_hist[(gi+MAIN_TAP)*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
        end else begin : g_new
            assign w_win[gi*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH] =
                input_data[(gi-KEEP)*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
        end
    end

    always_comb begin
        w_fill_next = r_fill;
        if (in_sof) begin
            w_fill_next = CNT_W'(MAIN_TAP);
        end else if (r_fill >= CNT_W'(KEEP)) begin
            w_fill_next = CNT_W'(TOTAL_TAP);
        end else begin
            w_fill_next = r_fill + CNT_W'(MAIN_TAP);
        end
    end

    assign w_pad_next = (w_fill_next < CNT_W'(TOTAL_TAP));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (w_xfer) begin
            r_hist <= w_win;
            r_fill <= w_fill_next;
        end
    end

`ifdef FP_TAP_WINDOW_SKID_EN
    logic [WIN_W:0] w_m_data;

    fp_skid_buffer #(
        .WIDTH      (WIN_W + 1),
        .RESET_DATA ((WIN_W + 1)'(1))
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .i_s_valid (in_valid),
        .o_s_ready (in_ready),
        .i_s_data  ({w_win, w_pad_next}),
        .o_m_valid (out_valid),
        .i_m_ready (out_ready),
        .o_m_data  (w_m_data)
    );

    assign input_data_all = w_m_data[WIN_W:1];
    assign out_pad        = w_m_data[0];
`else
    logic             r_out_valid;
    logic             r_out_pad;
    logic [WIN_W-1:0] r_out_data;

    // A new window replaces the old one even when it is being drained this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_pad   <= 1'b1;
            r_out_data  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_pad   <= w_pad_next;
            r_out_data  <= w_win;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready       = !r_out_valid || out_ready;
    assign out_valid      = r_out_valid;
    assign out_pad        = r_out_pad;
    assign input_data_all = r_out_data;
`endif

endmodule

// File: tb/tb_fp_tap_window.sv
// Directed and throttled-random checks for fp_tap_window (default parameters).
module tb_fp_tap_window;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sof = 1'b0;
    logic [15:0] input_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] input_data_all;
    logic        out_pad;

    int n_cmp = 0;
    int n_err = 0;

`ifdef FP_TAP_WINDOW_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    fp_tap_window dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sof         (in_sof),
        .input_data     (input_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .input_data_all (input_data_all),
        .out_pad        (out_pad)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model of zero-initialised sliding windows, sampled at negedge.
    typedef struct { logic [31:0] win; logic pad; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] obs_q[$];
    sample_t     mh[4];
    int          mfill = 0;

    always @(negedge clk) begin
        if (reset) begin
            foreach (mh[i]) mh[i] = '0;
            mfill = 0;
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_window", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_data", input_data_all, e.win);
                    chk("sb_pad", {31'd0, out_pad}, {31'd0, e.pad});
                end
                obs_q.push_back(input_data_all);
            end
            if (in_valid && in_ready) begin
                exp_t e;
                if (in_sof) begin
                    mh[0] = '0; mh[1] = '0; mfill = 2;
                end else begin
                    mh[0] = mh[2]; mh[1] = mh[3];
                    mfill = (mfill + 2 > 4) ? 4 : mfill + 2;
                end
                mh[2] = sample_t'(input_data[7:0]);
                mh[3] = sample_t'(input_data[15:8]);
                e.win = {mh[3], mh[2], mh[1], mh[0]};
                e.pad = (mfill < 4);
                exp_q.push_back(e);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the transfer edge.
    task automatic send_word(input logic sof, input logic [15:0] data);
        int waited = 0;
        in_valid = 1'b1; in_sof = sof; input_data = data;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0; in_sof = 1'b0;
                return;
            end
            @(posedge clk); #1;
            waited++;
            if (waited > 50) begin
                chk("send_timeout", 32'd1, 32'd0);
                in_valid = 1'b0; in_sof = 1'b0;
                return;
            end
        end
    endtask

    typedef struct { logic sof; logic [15:0] din; logic [31:0] win; logic pad; } vec_t;
    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc, guard, sent, cyc;
        logic acc;

        vecs[0] = '{1'b1, 16'h0201, 32'h02010000, 1'b1};
        vecs[1] = '{1'b0, 16'h0403, 32'h04030201, 1'b0};
        vecs[2] = '{1'b0, 16'h0605, 32'h06050403, 1'b0};
        vecs[3] = '{1'b1, 16'h0B0A, 32'h0B0A0000, 1'b1};
        vecs[4] = '{1'b0, 16'h0D0C, 32'h0D0C0B0A, 1'b0};
        vecs[5] = '{1'b0, 16'h0F0E, 32'h0F0E0D0C, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_pad", {31'd0, out_pad}, 32'd1);
        chk("rst_data", input_data_all, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, SKID ? 32'd0 : 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Table-driven words with out_ready held high
        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].sof, vecs[i].din);
            @(negedge clk);
            $display("vec %0d: sof=%0b din=%h -> win=%h pad=%0b", i, vecs[i].sof, vecs[i].din,
                     input_data_all, out_pad);
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_data", i), input_data_all, vecs[i].win);
            chk($sformatf("vec%0d_pad", i), {31'd0, out_pad}, {31'd0, vecs[i].pad});
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // Backpressure: window A parked at the output, B then C offered
        obs_q.delete();
        out_ready = 1'b0;
        send_word(1'b0, 16'h1312);
        in_valid = 1'b1; input_data = 16'h1514;
        nacc = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_in_ready", k), {31'd0, in_ready},
                (SKID && k == 0) ? 32'd1 : 32'd0);
            chk($sformatf("stall%0d_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("stall%0d_data", k), input_data_all, 32'h13120F0E);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin
                nacc++;
                input_data = 16'h1716;
            end
        end
        chk("stall_accepted", nacc, SKID ? 32'd1 : 32'd0);
        out_ready = 1'b1;
        guard = 0;
        while (nacc < 2 && guard < 50) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                nacc++;
                if (nacc == 1) input_data = 16'h1716;
                if (nacc == 2) in_valid = 1'b0;
            end
            guard++;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("release_count", obs_q.size(), 32'd3);
        if (obs_q.size() == 3) begin
            $display("release: %h %h %h", obs_q[0], obs_q[1], obs_q[2]);
            chk("release_w0", obs_q[0], 32'h13120F0E);
            chk("release_w1", obs_q[1], 32'h15141312);
            chk("release_w2", obs_q[2], 32'h17161514);
        end

        // Reset while a window is pending
        send_word(1'b0, 16'h3130);
        out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("pre_rst_data", input_data_all, 32'h31301716);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_pad", {31'd0, out_pad}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_word(1'b0, 16'h2211);
        @(negedge clk);
        $display("post-reset word: win=%h pad=%0b", input_data_all, out_pad);
        chk("postrst_data", input_data_all, 32'h22110000);
        chk("postrst_pad", {31'd0, out_pad}, 32'd1);
        @(posedge clk); #1;

        // Random valid/ready throttling, checked by the scoreboard
        sent = 0; cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            out_ready = ($urandom_range(3) != 0);
            if (!in_valid && $urandom_range(1) == 1) begin
                in_valid   = 1'b1;
                input_data = 16'($urandom);
                in_sof     = ($urandom_range(49) == 0);
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                in_valid = 1'b0; in_sof = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        $display("random phase: %0d words in %0d cycles", sent, cyc);
        chk("random_sent", sent, 32'd1000);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_tap_window.md
# fp_tap_window

Sliding tap-window assembler directly upstream of the neural-network equalizer. It accepts MAIN_TAP new samples per transfer and keeps a zero-initialised history of the last TOTAL_TAP samples. For every accepted input word it presents the full window, pre-taps plus main taps plus post-taps, as the flat `input_data_all` bus. It provides valid/ready flow control and frame-start history clearing, plus a padding flag so downstream can ignore windows that still contain pre-frame zeros.

## Interface
- MAIN_TAP, 2, samples per input word; number of equalizer outputs
- PRE_TAP, 1, history samples older than the main block
- POST_TAP, 1, samples newer than the main block
- INPUT_DATA_WIDTH, 8, bits per sample, signed two's complement
- TOTAL_TAP (localparam), PRE_TAP+MAIN_TAP+POST_TAP
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept input
- in_sof  in  1  first word of a frame; qualified by in_valid
- input_data  in  INPUT_DATA_WIDTH*MAIN_TAP  new samples; lane 0 (LSBs) is the earliest sample
- out_valid  out  1  window valid
- out_ready  in  1  downstream accepts window
- input_data_all  out  INPUT_DATA_WIDTH*TOTAL_TAP  window; lane 0 = oldest, lane TOTAL_TAP-1 = newest
- out_pad  out  1  window contains at least one zero-padded (pre-frame) position

## Operation
- The history register holds TOTAL_TAP samples, all zero after reset.
- Input transfer: in_valid && in_ready.
  - The history shifts toward lane 0 by MAIN_TAP.
  - input_data lanes 0..MAIN_TAP-1 enter at history lanes TOTAL_TAP-MAIN_TAP..TOTAL_TAP-1.
  - If in_sof=1, the older part of the history is zeroed before the shift. The resulting window holds zeros except for the new word.
- Fill counter: counts samples since the last sof or reset, saturating at TOTAL_TAP.
  - Each transfer adds MAIN_TAP. An sof transfer loads MAIN_TAP.
  - out_pad for a window = (count after the transfer < TOTAL_TAP).
- One window is produced per input transfer; the block never drops or duplicates windows.
- Output register: {input_data_all, out_pad, out_valid}.
  - Loaded on every input transfer.
  - out_valid clears when out_ready is high and no new transfer occurs.
- in_ready without skid: in_ready = !out_valid || out_ready (combinational pass-through).
- Simultaneous output drain and input transfer in the same cycle: out_valid stays 1, and the data is replaced.
- out_valid && !out_ready: the output holds stable, with no change to data or out_pad.
- in_valid low: no shift, no count change, no output.
- Parameter checks at elaboration: MAIN_TAP ≥ 1, PRE_TAP ≥ 0, POST_TAP ≥ 0, INPUT_DATA_WIDTH ≥ 7.
  - The width check exists because downstream slices bits [6:5].

## Timing
- Reset values: out_valid=0, input_data_all=0, out_pad=1, history=0, fill count=0.
- in_ready during reset: 0 with skid, 1 without skid.
- Latency: a window appears on out_valid exactly 1 clk after its input transfer.
- Throughput: 1 window/clk while out_ready=1.
- Reset asserted mid-stream: the history and any pending window are discarded on that edge. The first post-reset window is padded.
- in_sof on a stalled cycle (in_ready=0) has no effect. It takes effect only on the cycle the transfer completes.

## Configuration
- FP_TAP_WINDOW_SKID_EN defined:
  - A 1-entry skid buffer sits between the history stage and the output register.
  - in_ready is a flop, equal to !skid_full.
  - Full throughput is preserved under backpressure, with no combinational path from out_ready to in_ready.
  - Latency stays 1 clk when the skid is empty and is 2 clk when the window was parked in the skid.
- FP_TAP_WINDOW_SKID_EN undefined: no skid buffer; in_ready behaves as in Operation.
- Window ordering and contents are identical in both builds.

## Structure
- Shared package fp_pkg holds:
  - a total_tap(pre, main, post) function
  - a sample_t typedef (logic signed [INPUT_DATA_WIDTH-1:0]) used by this block and the equalizer
  - a FP_TAP_LANE_ORDER note constant stating "lane 0 = oldest"
- One sub-module, fp_skid_buffer: generic 1-entry valid/ready skid, parameterised on payload width. It is instantiated only under FP_TAP_WINDOW_SKID_EN.

## Test plan
All scenarios use default parameters.
- Reset, then word {lane0=0x01, lane1=0x02} with sof → next clk: out_valid=1, input_data_all=0x02010000, out_pad=1.
- Follow-up word {0x03,0x04} → input_data_all=0x04030201, out_pad=0; word {0x05,0x06} → 0x06050403, out_pad=0.
- Hold out_ready=0 for 3 clk with in_valid=1:
  - Without skid: in_ready=0 and the window is stable.
  - With skid: exactly one extra word is accepted, then in_ready=0.
  - On release, windows emerge in order with none lost.
- Mid-stream in_sof with word {0x0A,0x0B} → 0x0B0A0000, out_pad=1; the next word {0x0C,0x0D} → 0x0D0C0B0A, out_pad=0.
- Assert reset for 1 clk while out_valid=1 → next clk: out_valid=0, out_pad=1. A following non-sof word {0x11,0x22} → 0x22110000, out_pad=1.
- Random valid/ready throttling, 1000 words → the output stream matches a reference model of zero-initialised sliding windows exactly.
